// File: rtl/key_pkg.sv
// Shared definitions for the key debounce path.
//   key_state_t              per-channel debounce FSM state (2-bit, 00/01/10/11)
//   DEBOUNCE_CYCLES_DEFAULT  default settle time in clocks (20 ms at 50 MHz)
package key_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_t;

endpackage

// File: rtl/key_debounce_if.sv
// Bundle of key pins and the cleaned key signals derived from them.
//   key_n        raw active-low key pins (0 = pressed), asynchronous to the clock
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
//   led_n        active-low LED drive, toggles on every accepted press
// master: the pin side (drives key_n, observes the results)
// slave:  the debouncer (reads key_n, drives the results)
interface key_debounce_if #(
  parameter int unsigned NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] led_n;

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  led_n
  );

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output led_n
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, counter-based debounce FSM, registered
// level/press/release outputs and an active-low LED that toggles on each press.
//   clk            system clock
//   rst            asynchronous active-high reset
//   key_n_i        raw active-low key pin
//   key_level_o    debounced level, 1 = pressed
//   key_press_o    one-cycle pulse after an accepted press
//   key_release_o  one-cycle pulse after an accepted release
//   led_n_o        active-low LED drive
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic led_n_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            s;
  key_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            led_n_q, led_n_d;

  // Synchroniser resets to "released" so reset exit never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  assign s = sync_q[1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a reversal of s during a wait falls back to the stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CntOne;
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      PRESSED: begin
        if (s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CntOne;
        end
      end
      RELEASE_WAIT: begin
        if (!s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. The level only rises on PRESS_WAIT->PRESSED and only falls on
  // RELEASE_WAIT->IDLE, so its edges are exactly the press/release events.
  always_comb begin
    level_d   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    led_n_d   = press_d ? ~led_n_q : led_n_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      led_n_q   <= 1'b1;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_n_q   <= led_n_d;
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign led_n_o       = led_n_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS independent active-low push buttons into clean key
// signals for the LED logic. One key_debounce_ch per key, nothing else.
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   key_debounce_if slave: key_n in; key_level, key_press,
//         key_release, led_n out (all NUM_KEYS wide)
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  key_debounce_if.slave bus
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .key_n_i      (bus.key_n[i]),
      .key_level_o  (bus.key_level[i]),
      .key_press_o  (bus.key_press[i]),
      .key_release_o(bus.key_release[i]),
      .led_n_o      (bus.led_n[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  key_debounce_if #(.NUM_KEYS(4)) bus_if ();

  key_debounce #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.key_n = 4'b1111;
    #2;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) rst = 1'b0;
      tests_run++;
      if (bus_if.key_level !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_level cyc%0d: got %b expected 0000", k, bus_if.key_level);
      end
      tests_run++;
      if (bus_if.key_press !== 4'b0000 || bus_if.key_release !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_pulses cyc%0d: got press %b release %b expected 0000/0000",
                 k, bus_if.key_press, bus_if.key_release);
      end
      tests_run++;
      if (bus_if.led_n !== 4'b1111) begin
        tests_failed++;
        $display("FAIL reset_led cyc%0d: got %b expected 1111", k, bus_if.led_n);
      end
      tick();
    end
  endtask

  // key0: low 2, high 1, low 2, then high; never long enough to be accepted
  task automatic test_bounce();
    logic pat [16];
    for (int i = 0; i < 16; i++) pat[i] = 1'b1;
    pat[0] = 1'b0; pat[1] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus_if.key_n = {3'b111, pat[k]};
      tick();
      tests_run++;
      if (bus_if.key_press !== 4'b0000 || bus_if.key_level !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bounce cyc%0d: got press %b level %b expected 0000/0000",
                 k, bus_if.key_press, bus_if.key_level);
      end
      tests_run++;
      if (bus_if.led_n !== 4'b1111 || bus_if.key_release !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bounce_led cyc%0d: got led %b release %b expected 1111/0000",
                 k, bus_if.led_n, bus_if.key_release);
      end
    end
  endtask

  task automatic test_press(input logic [3:0] led_before, input logic [3:0] led_after);
    logic [3:0] exp_press, exp_level, exp_led;
    bus_if.key_n = 4'b1110;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_press = (k == 7) ? 4'b0001 : 4'b0000;
      exp_level = (k >= 7) ? 4'b0001 : 4'b0000;
      exp_led   = (k >= 7) ? led_after : led_before;
      tests_run++;
      if (bus_if.key_press !== exp_press) begin
        tests_failed++;
        $display("FAIL press_pulse edge%0d: got %b expected %b", k, bus_if.key_press, exp_press);
      end
      tests_run++;
      if (bus_if.key_level !== exp_level) begin
        tests_failed++;
        $display("FAIL press_level edge%0d: got %b expected %b", k, bus_if.key_level, exp_level);
      end
      tests_run++;
      if (bus_if.led_n !== exp_led) begin
        tests_failed++;
        $display("FAIL press_led edge%0d: got %b expected %b", k, bus_if.led_n, exp_led);
      end
    end
  endtask

  task automatic test_release(input logic [3:0] led_hold);
    logic [3:0] exp_rel, exp_level;
    bus_if.key_n = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_rel   = (k == 7) ? 4'b0001 : 4'b0000;
      exp_level = (k >= 7) ? 4'b0000 : 4'b0001;
      tests_run++;
      if (bus_if.key_release !== exp_rel || bus_if.key_press !== 4'b0000) begin
        tests_failed++;
        $display("FAIL release_pulse edge%0d: got release %b press %b expected %b/0000",
                 k, bus_if.key_release, bus_if.key_press, exp_rel);
      end
      tests_run++;
      if (bus_if.key_level !== exp_level) begin
        tests_failed++;
        $display("FAIL release_level edge%0d: got %b expected %b", k, bus_if.key_level, exp_level);
      end
      tests_run++;
      if (bus_if.led_n !== led_hold) begin
        tests_failed++;
        $display("FAIL release_led edge%0d: got %b expected %b", k, bus_if.led_n, led_hold);
      end
    end
  endtask

  task automatic test_multi_and_reset();
    logic [3:0] exp_press, exp_level;
    bus_if.key_n = 4'b0101;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_press = (k == 7) ? 4'b1010 : 4'b0000;
      exp_level = (k >= 7) ? 4'b1010 : 4'b0000;
      tests_run++;
      if (bus_if.key_press !== exp_press) begin
        tests_failed++;
        $display("FAIL multi_press edge%0d: got %b expected %b", k, bus_if.key_press, exp_press);
      end
      tests_run++;
      if (bus_if.key_level !== exp_level) begin
        tests_failed++;
        $display("FAIL multi_level edge%0d: got %b expected %b", k, bus_if.key_level, exp_level);
      end
    end
    tests_run++;
    if (bus_if.led_n !== 4'b0101) begin
      tests_failed++;
      $display("FAIL multi_led: got %b expected 0101", bus_if.led_n);
    end
    // key2 pressed too, reset lands while its count is in progress
    bus_if.key_n = 4'b0001;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus_if.key_level !== 4'b0000 || bus_if.key_press !== 4'b0000 ||
        bus_if.key_release !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got level %b press %b release %b expected 0000/0000/0000",
               bus_if.key_level, bus_if.key_press, bus_if.key_release);
    end
    tests_run++;
    if (bus_if.led_n !== 4'b1111) begin
      tests_failed++;
      $display("FAIL midreset_led: got %b expected 1111", bus_if.led_n);
    end
    bus_if.key_n = 4'b1111;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      tests_run++;
      if (bus_if.key_level !== 4'b0000 || bus_if.key_press !== 4'b0000 ||
          bus_if.key_release !== 4'b0000 || bus_if.led_n !== 4'b1111) begin
        tests_failed++;
        $display("FAIL post_reset cyc%0d: got level %b press %b release %b led %b expected 0000/0000/0000/1111",
                 k, bus_if.key_level, bus_if.key_press, bus_if.key_release, bus_if.led_n);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus_if.key_n = 4'b1111;
    test_reset();
    test_bounce();
    test_press(4'b1111, 4'b1110);
    test_release(4'b1110);
    test_press(4'b1110, 4'b1111);
    test_release(4'b1111);
    test_multi_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
